mole_scheduler: RTL and testbench

//  Consumer of the 6-bit LFSR value: turns random values into a timed sequence of mole pop-ups
//  for the whack-a-mole game. Drives one-hot mole LEDs, judges debounced button hits, keeps score/miss counts.

---
 rtl/mole_pkg.sv | 21 ++
 rtl/mole_timer.sv | 30 +++
 rtl/mole_scheduler.sv | 148 ++++++++++++++
 tb/tb_mole_scheduler.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole scheduler.
// Holds the FSM state encoding and the hole-index selection rule.
package mole_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int NUM_MOLES = 8;
    localparam int IDX_W     = 3;

    // Never pop the same hole twice in a row: step to the neighbour, wrapping at 8.
    function automatic logic [IDX_W-1:0] pick_idx(input logic [IDX_W-1:0] cand,
                                                  input logic [IDX_W-1:0] last);
        return (cand == last) ? cand + 3'd1 : cand;
    endfunction

endpackage

// File: rtl/mole_timer.sv
// Loadable tick-enabled down counter, shared by the gap and mole-up phases.
// Load has priority over decrement; the count holds at zero.
module mole_timer #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/mole_scheduler.sv
// Turns LFSR values into a timed sequence of mole pop-ups and judges button hits.
// Two-process FSM; all outputs come straight from registers.
//
// state | meaning
// IDLE  | no game since reset, waiting for start
// GAP   | dark interval between moles, gap timer running
// UP    | one mole lit, up timer running, judging presses
// DONE  | all rounds resolved, game_over high until next start
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int UP_TICKS = 750,
    parameter int GAP_BASE = 200,
    parameter int GAP_STEP = 50,
    parameter int ROUNDS   = 30,
    parameter int CNT_W    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    input  logic                 i_start,
    input  logic [5:0]           i_rand_q,
    input  logic [NUM_MOLES-1:0] i_btn,
    output logic [NUM_MOLES-1:0] o_mole_led,
    output logic [CNT_W-1:0]     o_score,
    output logic [CNT_W-1:0]     o_miss,
    output logic                 o_busy,
    output logic                 o_game_over
);

    localparam int GAP_MAX = GAP_BASE + GAP_STEP * 7;
    localparam int TMR_MAX = (UP_TICKS > GAP_MAX) ? UP_TICKS : GAP_MAX;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RND_W   = $clog2(ROUNDS + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t               r_state, w_state_n;
    logic [NUM_MOLES-1:0] r_led, w_led_n;
    logic [CNT_W-1:0]     r_score, w_score_n, r_miss, w_miss_n;
    logic [RND_W-1:0]     r_round, w_round_n;
    logic [IDX_W-1:0]     r_last, w_last_n, w_idx;
    logic                 r_busy, w_busy_n, r_over, w_over_n;
    logic                 w_tmr_load, w_zero, w_expire, w_hit, w_wrong;
    logic [TMR_W-1:0]     w_tmr_val, w_gap, w_count;

    mole_timer #(.W(TMR_W)) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tick     (i_tick),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // Expiry is the tick that takes the counter to zero, not the cycle after.
    assign w_expire = i_tick && (w_zero || (w_count == TMR_W'(1)));
    assign w_gap    = TMR_W'(GAP_BASE + GAP_STEP * int'(i_rand_q[5:3]));
    assign w_idx    = pick_idx(i_rand_q[2:0], r_last);
    assign w_hit    = |(i_btn & r_led);
    assign w_wrong  = |(i_btn & ~r_led);

    always_comb begin
        w_state_n  = r_state;
        w_led_n    = r_led;
        w_score_n  = r_score;
        w_miss_n   = r_miss;
        w_round_n  = r_round;
        w_last_n   = r_last;
        w_busy_n   = r_busy;
        w_over_n   = r_over;
        w_tmr_load = 1'b0;
        w_tmr_val  = w_gap;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_score_n  = '0;
                    w_miss_n   = '0;
                    w_round_n  = '0;
                    w_over_n   = 1'b0;
                    w_busy_n   = 1'b1;
                    w_tmr_load = 1'b1;
                    w_state_n  = S_GAP;
                end
            end
            S_GAP: begin
                if (w_expire) begin
                    w_led_n    = {{(NUM_MOLES-1){1'b0}}, 1'b1} << w_idx;
                    w_last_n   = w_idx;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(UP_TICKS);
                    w_state_n  = S_UP;
                end
            end
            S_UP: begin
                if (w_hit || w_expire) begin
                    if (w_hit) w_score_n = sat_inc(r_score);
                    else       w_miss_n  = sat_inc(r_miss);
                    w_led_n   = '0;
                    w_round_n = r_round + 1'b1;
                    if (r_round == RND_W'(ROUNDS - 1)) begin
                        w_busy_n  = 1'b0;
                        w_over_n  = 1'b1;
                        w_state_n = S_DONE;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_state_n  = S_GAP;
                    end
                end else if (w_wrong) begin
                    w_miss_n = sat_inc(r_miss);
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_led   <= '0;
            r_score <= '0;
            r_miss  <= '0;
            r_round <= '0;
            r_last  <= '0;
            r_busy  <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_led   <= w_led_n;
            r_score <= w_score_n;
            r_miss  <= w_miss_n;
            r_round <= w_round_n;
            r_last  <= w_last_n;
            r_busy  <= w_busy_n;
            r_over  <= w_over_n;
        end
    end

    assign o_mole_led  = r_led;
    assign o_score     = r_score;
    assign o_miss      = r_miss;
    assign o_busy      = r_busy;
    assign o_game_over = r_over;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with short timing parameters.
// Expected output snapshots are queued as each step is driven and popped after the clock edge.
module tb_mole_scheduler;

    localparam int UP_T  = 10;
    localparam int CNT_W = 8;

    typedef struct {
        string      tag;
        logic [7:0] led;
        logic [7:0] score;
        logic [7:0] miss;
        logic       busy;
        logic       over;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             start = 1'b0;
    logic [5:0]       rand_q = '0;
    logic [7:0]       btn = '0;
    logic [7:0]       mole_led;
    logic [CNT_W-1:0] score, miss;
    logic             busy, game_over;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mole_scheduler #(
        .UP_TICKS (UP_T),
        .GAP_BASE (4),
        .GAP_STEP (2),
        .ROUNDS   (3),
        .CNT_W    (CNT_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tick      (tick),
        .i_start     (start),
        .i_rand_q    (rand_q),
        .i_btn       (btn),
        .o_mole_led  (mole_led),
        .o_score     (score),
        .o_miss      (miss),
        .o_busy      (busy),
        .o_game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string f, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] led, input logic [7:0] sc,
                        input logic [7:0] ms, input logic bz, input logic ov);
        exp_t e;
        e.tag = tag; e.led = led; e.score = sc; e.miss = ms; e.busy = bz; e.over = ov;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.tag, "led",   mole_led,        e.led);
        cmp(e.tag, "score", score,           e.score);
        cmp(e.tag, "miss",  miss,            e.miss);
        cmp(e.tag, "busy",  {7'd0, busy},     {7'd0, e.busy});
        cmp(e.tag, "over",  {7'd0, game_over}, {7'd0, e.over});
    endtask

    task automatic drive(input logic t, input logic s, input logic [7:0] b);
        tick = t; start = s; btn = b;
        @(posedge clk);
        #1;
        tick = 1'b0; start = 1'b0; btn = '0;
    endtask

    task automatic cyc(input logic t, input logic s, input logic [7:0] b, input string tag,
                       input logic [7:0] led, input logic [7:0] sc, input logic [7:0] ms,
                       input logic bz, input logic ov);
        push(tag, led, sc, ms, bz, ov);
        drive(t, s, b);
        pop_check();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #3;
        push("reset", 8'h00, 0, 0, 1'b0, 1'b0);
        pop_check();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Game 1: gap 4, idx 3
        rand_q = 6'b000_011;
        cyc(0, 1, 8'h00, "start",    8'h00, 0, 0, 1, 0);
        ticks(2);
        cyc(1, 0, 8'h00, "gap_t3",   8'h00, 0, 0, 1, 0);
        cyc(1, 0, 8'h00, "pop08",    8'h08, 0, 0, 1, 0);
        cyc(0, 0, 8'h21, "wrong",    8'h08, 0, 1, 1, 0);
        cyc(1, 0, 8'h00, "up_t1",    8'h08, 0, 1, 1, 0);
        cyc(1, 0, 8'h08, "hit08",    8'h00, 1, 1, 1, 0);
        // Round 2: repeat of idx 3 bumps to 4; ends by timeout
        cyc(0, 0, 8'hff, "gap_btn",  8'h00, 1, 1, 1, 0);
        ticks(3);
        cyc(1, 0, 8'h00, "pop10",    8'h10, 1, 1, 1, 0);
        cyc(0, 1, 8'h00, "start_up", 8'h10, 1, 1, 1, 0);
        ticks(UP_T - 2);
        cyc(1, 0, 8'h00, "up_last",  8'h10, 1, 1, 1, 0);
        rand_q = 6'b000_100;
        cyc(1, 0, 8'h00, "timeout",  8'h00, 1, 2, 1, 0);
        // Round 3: repeat of idx 4 bumps to 5; hit plus wrong bit counts as hit only
        ticks(3);
        cyc(1, 0, 8'h00, "pop20",    8'h20, 1, 2, 1, 0);
        cyc(1, 0, 8'h21, "hit_mix",  8'h00, 2, 2, 0, 1);
        cyc(1, 0, 8'h00, "done",     8'h00, 2, 2, 0, 1);

        // Game 2: restart from DONE, last_idx carries over as 5
        rand_q = 6'b000_101;
        cyc(0, 1, 8'h00, "restart",  8'h00, 0, 0, 1, 0);
        ticks(3);
        cyc(1, 0, 8'h00, "pop40",    8'h40, 0, 0, 1, 0);
        rand_q = 6'b001_111;
        cyc(0, 0, 8'h40, "hit40",    8'h00, 1, 0, 1, 0);
        ticks(4);
        cyc(1, 0, 8'h00, "gap6_t5",  8'h00, 1, 0, 1, 0);
        cyc(1, 0, 8'h00, "pop80",    8'h80, 1, 0, 1, 0);
        rand_q = 6'b000_111;
        cyc(0, 0, 8'h80, "hit80",    8'h00, 2, 0, 1, 0);
        ticks(3);
        cyc(1, 0, 8'h00, "pop01",    8'h01, 2, 0, 1, 0);

        // Asynchronous reset mid-UP
        #2 rst = 1'b1;
        #1;
        push("rst_async", 8'h00, 0, 0, 1'b0, 1'b0);
        pop_check();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 0, 8'h00, "idle1",    8'h00, 0, 0, 0, 0);
        cyc(1, 0, 8'h04, "idle2",    8'h00, 0, 0, 0, 0);

        // last_idx cleared by reset: rand idx 0 bumps to 1
        rand_q = 6'b000_000;
        cyc(0, 1, 8'h00, "start3",   8'h00, 0, 0, 1, 0);
        ticks(3);
        cyc(1, 0, 8'h00, "pop02",    8'h02, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
